// File: rtl/multicycle_sequencer_pkg.sv
// Shared types and encodings for the multi-cycle control path: FSM states,
// RV32I opcodes, instruction classes and datapath select encodings.
package multicycle_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4
  } state_t;

  localparam int unsigned OPCODE_WIDTH = 7;

  localparam logic [OPCODE_WIDTH-1:0] OPC_LOAD     = 7'b0000011;
  localparam logic [OPCODE_WIDTH-1:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [OPCODE_WIDTH-1:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [OPCODE_WIDTH-1:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [OPCODE_WIDTH-1:0] OPC_STORE    = 7'b0100011;
  localparam logic [OPCODE_WIDTH-1:0] OPC_OP       = 7'b0110011;
  localparam logic [OPCODE_WIDTH-1:0] OPC_LUI      = 7'b0110111;
  localparam logic [OPCODE_WIDTH-1:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [OPCODE_WIDTH-1:0] OPC_JALR     = 7'b1100111;
  localparam logic [OPCODE_WIDTH-1:0] OPC_JAL      = 7'b1101111;
  localparam logic [OPCODE_WIDTH-1:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [3:0] {
    CLS_ALU_R   = 4'd0,
    CLS_ALU_I   = 4'd1,
    CLS_LOAD    = 4'd2,
    CLS_STORE   = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_JAL     = 4'd5,
    CLS_JALR    = 4'd6,
    CLS_LUI     = 4'd7,
    CLS_AUIPC   = 4'd8,
    CLS_NOP     = 4'd9,
    CLS_ILLEGAL = 4'd10
  } inst_class_t;

  localparam logic [1:0] NPC_PLUS4  = 2'd0;
  localparam logic [1:0] NPC_BRANCH = 2'd1;
  localparam logic [1:0] NPC_JAL    = 2'd2;
  localparam logic [1:0] NPC_JALR   = 2'd3;

  localparam logic [2:0] WB_ALU = 3'd0;
  localparam logic [2:0] WB_MEM = 3'd1;
  localparam logic [2:0] WB_PC4 = 3'd2;
  localparam logic [2:0] WB_IMM = 3'd3;

  localparam logic [1:0] ALU_ADD    = 2'd0;
  localparam logic [1:0] ALU_BRANCH = 2'd1;
  localparam logic [1:0] ALU_OP     = 2'd2;
  localparam logic [1:0] ALU_OP_IMM = 2'd3;

endpackage

// File: rtl/multicycle_sequencer_decode.sv
// Maps the instruction-register opcode onto the instruction class that the
// sequencer FSM and its output logic switch on.
module multicycle_sequencer_decode
  import multicycle_sequencer_pkg::*;
(
  input  logic [OPCODE_WIDTH-1:0] inst_opcode,
  output inst_class_t             inst_class
);

  always_comb begin
    inst_class = CLS_ILLEGAL;
    case (inst_opcode)
      OPC_OP:       inst_class = CLS_ALU_R;
      OPC_OP_IMM:   inst_class = CLS_ALU_I;
      OPC_LOAD:     inst_class = CLS_LOAD;
      OPC_STORE:    inst_class = CLS_STORE;
      OPC_BRANCH:   inst_class = CLS_BRANCH;
      OPC_JAL:      inst_class = CLS_JAL;
      OPC_JALR:     inst_class = CLS_JALR;
      OPC_LUI:      inst_class = CLS_LUI;
      OPC_AUIPC:    inst_class = CLS_AUIPC;
      OPC_MISC_MEM: inst_class = CLS_NOP;
      OPC_SYSTEM:   inst_class = CLS_NOP;
      default:      inst_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK control FSM sharing one
// memory port, with a wrapping retired-instruction counter.
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [OPCODE_WIDTH-1:0] inst_opcode,
  input  logic                    take_branch,
  input  logic                    mem_ready,
  output logic                    mem_address_select,
  output logic                    mem_read_enable,
  output logic                    mem_write_enable,
  output logic                    ir_write_enable,
  output logic                    pc_write_enable,
  output logic [1:0]              next_pc_select,
  output logic                    regfile_write_enable,
  output logic                    alu_operand_a_select,
  output logic                    alu_operand_b_select,
  output logic [1:0]              alu_op_type,
  output logic [2:0]              reg_writeback_select,
  output logic                    illegal_inst,
  output logic [COUNT_WIDTH-1:0]  retired_count
);

  state_t                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   illegal_q, illegal_d;
  logic                   retire_c;
  inst_class_t            inst_class;
  logic                   alu_a_c, alu_b_c;
  logic [1:0]             alu_type_c;

  multicycle_sequencer_decode u_decode (
    .inst_opcode (inst_opcode),
    .inst_class  (inst_class)
  );

  // ALU operand/op selection per class; applied in EXECUTE and held through MEM
  always_comb begin
    alu_a_c    = 1'b0;
    alu_b_c    = 1'b0;
    alu_type_c = ALU_ADD;
    case (inst_class)
      CLS_ALU_R:  alu_type_c = ALU_OP;
      CLS_ALU_I: begin
        alu_b_c    = 1'b1;
        alu_type_c = ALU_OP_IMM;
      end
      CLS_LOAD, CLS_STORE, CLS_JALR: alu_b_c = 1'b1;
      CLS_AUIPC: begin
        alu_a_c = 1'b1;
        alu_b_c = 1'b1;
      end
      CLS_BRANCH: alu_type_c = ALU_BRANCH;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state and datapath controls; everything stays 0 while reset is high
  always_comb begin
    state_d              = state_q;
    illegal_d            = 1'b0;
    retire_c             = 1'b0;
    mem_address_select   = 1'b0;
    mem_read_enable      = 1'b0;
    mem_write_enable     = 1'b0;
    ir_write_enable      = 1'b0;
    pc_write_enable      = 1'b0;
    next_pc_select       = NPC_PLUS4;
    regfile_write_enable = 1'b0;
    alu_operand_a_select = 1'b0;
    alu_operand_b_select = 1'b0;
    alu_op_type          = ALU_ADD;
    reg_writeback_select = WB_ALU;
    if (!reset) begin
      case (state_q)
        ST_FETCH: begin
          mem_read_enable = 1'b1;
          if (mem_ready) begin
            ir_write_enable = 1'b1;
            state_d         = ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (inst_class == CLS_ILLEGAL) begin
            pc_write_enable = 1'b1;
            illegal_d       = 1'b1;
            state_d         = ST_FETCH;
          end else begin
            state_d = ST_EXECUTE;
          end
        end
        ST_EXECUTE: begin
          alu_operand_a_select = alu_a_c;
          alu_operand_b_select = alu_b_c;
          alu_op_type          = alu_type_c;
          if (inst_class == CLS_BRANCH) begin
            pc_write_enable = 1'b1;
            next_pc_select  = take_branch ? NPC_BRANCH : NPC_PLUS4;
            retire_c        = 1'b1;
            state_d         = ST_FETCH;
          end else if (inst_class == CLS_LOAD || inst_class == CLS_STORE) begin
            state_d = ST_MEM;
          end else begin
            state_d = ST_WRITEBACK;
          end
        end
        ST_MEM: begin
          mem_address_select   = 1'b1;
          alu_operand_a_select = alu_a_c;
          alu_operand_b_select = alu_b_c;
          alu_op_type          = alu_type_c;
          if (inst_class == CLS_LOAD) begin
            mem_read_enable = 1'b1;
            if (mem_ready) state_d = ST_WRITEBACK;
          end else if (inst_class == CLS_STORE) begin
            mem_write_enable = 1'b1;
            if (mem_ready) begin
              pc_write_enable = 1'b1;
              retire_c        = 1'b1;
              state_d         = ST_FETCH;
            end
          end else begin
            state_d = ST_FETCH;
          end
        end
        ST_WRITEBACK: begin
          pc_write_enable = 1'b1;
          retire_c        = 1'b1;
          state_d         = ST_FETCH;
          case (inst_class)
            CLS_ALU_R, CLS_ALU_I, CLS_AUIPC: regfile_write_enable = 1'b1;
            CLS_LOAD: begin
              regfile_write_enable = 1'b1;
              reg_writeback_select = WB_MEM;
            end
            CLS_LUI: begin
              regfile_write_enable = 1'b1;
              reg_writeback_select = WB_IMM;
            end
            CLS_JAL: begin
              regfile_write_enable = 1'b1;
              reg_writeback_select = WB_PC4;
              next_pc_select       = NPC_JAL;
            end
            CLS_JALR: begin
              regfile_write_enable = 1'b1;
              reg_writeback_select = WB_PC4;
              next_pc_select       = NPC_JALR;
            end
            default: ;
          endcase
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  assign count_d       = retire_c ? count_q + COUNT_WIDTH'(1) : count_q;
  assign retired_count = count_q;
  assign illegal_inst  = illegal_q & ~reset;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: per-cycle expected control
// vectors are queued per instruction and compared as the FSM steps.
module tb_multicycle_sequencer;

  localparam int unsigned CW = 4;

  logic          clock;
  logic          reset;
  logic [6:0]    inst_opcode;
  logic          take_branch;
  logic          mem_ready;
  logic          mem_address_select;
  logic          mem_read_enable;
  logic          mem_write_enable;
  logic          ir_write_enable;
  logic          pc_write_enable;
  logic [1:0]    next_pc_select;
  logic          regfile_write_enable;
  logic          alu_operand_a_select;
  logic          alu_operand_b_select;
  logic [1:0]    alu_op_type;
  logic [2:0]    reg_writeback_select;
  logic          illegal_inst;
  logic [CW-1:0] retired_count;

  multicycle_sequencer #(.COUNT_WIDTH(CW)) dut (
    .clock                (clock),
    .reset                (reset),
    .inst_opcode          (inst_opcode),
    .take_branch          (take_branch),
    .mem_ready            (mem_ready),
    .mem_address_select   (mem_address_select),
    .mem_read_enable      (mem_read_enable),
    .mem_write_enable     (mem_write_enable),
    .ir_write_enable      (ir_write_enable),
    .pc_write_enable      (pc_write_enable),
    .next_pc_select       (next_pc_select),
    .regfile_write_enable (regfile_write_enable),
    .alu_operand_a_select (alu_operand_a_select),
    .alu_operand_b_select (alu_operand_b_select),
    .alu_op_type          (alu_op_type),
    .reg_writeback_select (reg_writeback_select),
    .illegal_inst         (illegal_inst),
    .retired_count        (retired_count)
  );

  localparam logic [6:0] O_LOAD = 7'b0000011, O_MISC = 7'b0001111, O_OPI = 7'b0010011,
                         O_AUIPC = 7'b0010111, O_STORE = 7'b0100011, O_OP = 7'b0110011,
                         O_LUI = 7'b0110111, O_BR = 7'b1100011, O_JALR = 7'b1100111,
                         O_JAL = 7'b1101111, O_SYS = 7'b1110011;

  int            total = 0;
  int            bad = 0;
  logic [15:0]   exp_q[$];
  logic          rdy_q[$];
  logic [CW-1:0] exp_cnt;
  logic [15:0]   obs;

  assign obs = {mem_read_enable, mem_write_enable, mem_address_select, ir_write_enable,
                pc_write_enable, next_pc_select, regfile_write_enable, alu_operand_a_select,
                alu_operand_b_select, alu_op_type, reg_writeback_select, illegal_inst};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] mk(input logic rd, input logic wr, input logic as,
                                     input logic ir, input logic pw, input logic [1:0] np,
                                     input logic rf, input logic [3:0] alu,
                                     input logic [2:0] wb, input logic il);
    return {rd, wr, as, ir, pw, np, rf, alu, wb, il};
  endfunction

  // {a_sel, b_sel, alu_op_type} expected in EXECUTE/MEM
  function automatic logic [3:0] alu_cfg(input logic [6:0] op);
    case (op)
      O_OP:                    return 4'b00_10;
      O_OPI:                   return 4'b01_11;
      O_LOAD, O_STORE, O_JALR: return 4'b01_00;
      O_AUIPC:                 return 4'b11_00;
      O_BR:                    return 4'b00_01;
      default:                 return 4'b00_00;
    endcase
  endfunction

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      O_LOAD, O_MISC, O_OPI, O_AUIPC, O_STORE, O_OP, O_LUI, O_BR, O_JALR, O_JAL, O_SYS:
        return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Queue the expected per-cycle trace for one instruction, then replay it
  task automatic run_inst(input logic [6:0] op, input logic tk, input int fw,
                          input int mw, input string name);
    logic [3:0]  a = alu_cfg(op);
    logic [15:0] e;
    logic        rf = 1'b0;
    logic [2:0]  wb = 3'd0;
    logic [1:0]  np = 2'd0;
    int          idx = 0;
    for (int i = 0; i < fw; i++) begin
      exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)); rdy_q.push_back(1'b0);
    end
    exp_q.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0)); rdy_q.push_back(1'b1);
    if (!is_legal(op)) begin
      exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0)); rdy_q.push_back(1'b1);
      exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1)); rdy_q.push_back(1'b0);
    end else begin
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); rdy_q.push_back(1'b1);
      if (op == O_BR) begin
        exp_q.push_back(mk(0, 0, 0, 0, 1, tk ? 2'd1 : 2'd0, 0, a, 0, 0)); rdy_q.push_back(1'b1);
        exp_cnt = exp_cnt + 1'b1;
      end else begin
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, a, 0, 0)); rdy_q.push_back(1'b1);
        if (op == O_LOAD || op == O_STORE) begin
          for (int i = 0; i < mw; i++) begin
            exp_q.push_back(mk(op == O_LOAD, op == O_STORE, 1, 0, 0, 0, 0, a, 0, 0));
            rdy_q.push_back(1'b0);
          end
          exp_q.push_back(mk(op == O_LOAD, op == O_STORE, 1, 0, op == O_STORE, 0, 0, a, 0, 0));
          rdy_q.push_back(1'b1);
        end
        if (op != O_STORE) begin
          case (op)
            O_OP, O_OPI, O_AUIPC: rf = 1'b1;
            O_LOAD: begin rf = 1'b1; wb = 3'd1; end
            O_LUI:  begin rf = 1'b1; wb = 3'd3; end
            O_JAL:  begin rf = 1'b1; wb = 3'd2; np = 2'd2; end
            O_JALR: begin rf = 1'b1; wb = 3'd2; np = 2'd3; end
            default: ;
          endcase
          exp_q.push_back(mk(0, 0, 0, 0, 1, np, rf, 0, wb, 0)); rdy_q.push_back(1'b1);
        end
        exp_cnt = exp_cnt + 1'b1;
      end
    end
    inst_opcode = op;
    take_branch = tk;
    while (exp_q.size() > 0) begin
      @(negedge clock);
      mem_ready = rdy_q.pop_front();
      #1;
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL %s cycle %0d: ctrl got %b want %b", name, idx, obs, e);
      end
      idx++;
    end
    @(posedge clock); #1;
    total++;
    if (retired_count !== exp_cnt) begin
      bad++;
      $display("FAIL %s retired_count: got %0d want %0d", name, retired_count, exp_cnt);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b1; inst_opcode = O_OP; take_branch = 1'b0;
    exp_cnt = '0;
    repeat (2) @(negedge clock);
    #1;
    total++;
    if (obs !== 16'd0) begin bad++; $display("FAIL reset_ctrl: got %b want 0", obs); end
    total++;
    if (retired_count !== '0) begin
      bad++; $display("FAIL reset_count: got %0d want 0", retired_count);
    end
    @(negedge clock);
    reset = 1'b0; mem_ready = 1'b0;
    #1;
    total++;
    if (obs !== mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)) begin
      bad++; $display("FAIL first_fetch: got %b want read request", obs);
    end
  endtask

  task automatic test_alu();
    run_inst(O_OP,    1'b1, 0, 0, "add");
    run_inst(O_OPI,   1'b0, 1, 0, "op_imm");
    run_inst(O_LUI,   1'b0, 0, 0, "lui");
    run_inst(O_AUIPC, 1'b1, 0, 0, "auipc");
  endtask

  task automatic test_load_wait();
    run_inst(O_LOAD, 1'b0, 2, 3, "load_wait");
    run_inst(O_LOAD, 1'b0, 0, 0, "load_fast");
  endtask

  task automatic test_store();
    run_inst(O_STORE, 1'b1, 0, 1, "store_wait");
    run_inst(O_STORE, 1'b0, 0, 0, "store_fast");
  endtask

  task automatic test_branch();
    run_inst(O_BR, 1'b1, 0, 0, "branch_taken");
    run_inst(O_BR, 1'b0, 0, 0, "branch_not_taken");
  endtask

  task automatic test_jumps_nops();
    run_inst(O_JALR, 1'b0, 0, 0, "jalr");
    run_inst(O_SYS,  1'b0, 0, 0, "system_nop");
  endtask

  task automatic test_illegal();
    run_inst(7'b0000000, 1'b0, 0, 0, "illegal");
    run_inst(O_OP, 1'b0, 0, 0, "after_illegal");
  endtask

  // Reset lands while a store is parked in MEM waiting on mem_ready
  task automatic test_reset_mid();
    inst_opcode = O_STORE; take_branch = 1'b0;
    @(negedge clock); mem_ready = 1'b1;
    @(negedge clock); mem_ready = 1'b1;
    @(negedge clock); mem_ready = 1'b1;
    @(negedge clock); mem_ready = 1'b0;
    #1;
    total++;
    if (mem_write_enable !== 1'b1) begin
      bad++; $display("FAIL mid_store_held: got %b want 1", mem_write_enable);
    end
    @(negedge clock); reset = 1'b1;
    #1;
    total++;
    if (obs !== 16'd0) begin bad++; $display("FAIL mid_reset_ctrl: got %b want 0", obs); end
    @(negedge clock); reset = 1'b0;
    #1;
    exp_cnt = '0;
    total++;
    if (obs !== mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)) begin
      bad++; $display("FAIL mid_reset_fetch: got %b want read request", obs);
    end
    total++;
    if (retired_count !== exp_cnt) begin
      bad++; $display("FAIL mid_reset_count: got %0d want 0", retired_count);
    end
  endtask

  task automatic test_wrap();
    int guard = 0;
    while (exp_cnt != {CW{1'b1}} && guard < 40) begin
      run_inst(O_MISC, 1'b0, 0, 0, "fill_nop");
      guard++;
    end
    run_inst(O_JAL, 1'b0, 0, 0, "jal_wrap");
    total++;
    if (retired_count !== '0) begin
      bad++; $display("FAIL wrap_count: got %0d want 0", retired_count);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_store();
    test_branch();
    test_jumps_nops();
    test_illegal();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
